// File: rtl/line_mem_responder_pkg.sv
// Shared types and geometry for the dcache-side line memory responder.
// Line geometry is 32-byte lines, 512 deep, indexed by byte-address bits [13:5].
package mem_line_pkg;

  localparam int LINE_W   = 256;
  localparam int DEPTH    = 512;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int LINE_OFS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Shift-then-truncate so that bits above the index simply drop out (aliasing).
  function automatic logic [IDX_W-1:0] line_idx(input logic [31:0] addr);
    return IDX_W'(addr >> LINE_OFS);
  endfunction

endpackage

// File: rtl/line_store.sv
// Single-port line array: synchronous write, registered read.
// The read register is the responder's data_o; it only moves on a read strobe.
module line_store #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [LINE_W-1:0]          wdata,
  output logic [LINE_W-1:0]          rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Array contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Backing-store responder for the dcache line interface: one request in flight,
// fixed latency from acceptance to a one-cycle ack_o pulse.
//
// state | meaning
// IDLE  | no request; enable_i at the edge latches a new request
// WAIT  | request latched, counting cycles since acceptance
// ACK   | ack_o high this cycle; array write / read register updated on entry
module line_mem_responder #(
  parameter int LINE_W  = mem_line_pkg::LINE_W,
  parameter int DEPTH   = mem_line_pkg::DEPTH,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  import mem_line_pkg::*;

  localparam logic [7:0] LAT8 = 8'(LATENCY);

  state_t            state;
  logic [7:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic              write_q;
  logic              commit;

  // The counter holds the number of edges since acceptance, so the ACK-entry
  // edge is exactly LATENCY edges after the accepting edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      ack_o   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            idx_q   <= line_idx(addr_i);
            data_q  <= data_i;
            write_q <= write_i;
            cnt_q   <= 8'd1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == LAT8) begin
            state <= ACK;
            ack_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack_o <= 1'b0;
        end
      endcase
    end
  end

  assign commit = (state == WAIT) && (cnt_q == LAT8);
  assign busy_o = (state != IDLE);

  line_store #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (commit && write_q),
    .re    (commit && !write_q),
    .idx   (idx_q),
    .wdata (data_q),
    .rdata (data_o)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: one instance at LATENCY=10, one at LATENCY=1.
module tb_line_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic         en0 = 1'b0, wr0 = 1'b0, en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  a0 = '0, a1 = '0;
  logic [255:0] d0 = '0, d1 = '0;
  logic         ack0, busy0, ack1, busy1;
  logic [255:0] q0, q1;

  int nvec = 0;
  int nmis = 0;
  int ackc0 = 0;
  int ackc1 = 0;
  logic [255:0] sb [$];
  logic [255:0] m0 [int];
  logic [255:0] m1 [int];

  int n_b, k_b, c_r;
  int at_b [2];

  localparam logic [255:0] PRE  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] ECFA = {16{16'hECFA}};
  localparam logic [255:0] L1D  = {8{32'h1234_5678}};
  localparam logic [255:0] CHD  = {8{32'hC0DE_0001}};
  localparam logic [255:0] OLD  = {8{32'h0D0D_0D0D}};
  localparam logic [255:0] NEWD = {8{32'hBADD_A7A0}};
  localparam logic [255:0] ALD  = {8{32'hA11A_5EED}};
  localparam logic [255:0] F1D  = {8{32'hFA57_0001}};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ack0) ackc0++;
    if (ack1) ackc1++;
  end

  line_mem_responder #(.LATENCY(10)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .addr_i(a0), .data_i(d0), .enable_i(en0),
    .write_i(wr0), .ack_o(ack0), .data_o(q0), .busy_o(busy0)
  );

  line_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .addr_i(a1), .data_i(d1), .enable_i(en1),
    .write_i(wr1), .ack_o(ack1), .data_o(q1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input bit s);
    return s ? ack1 : ack0;
  endfunction

  function automatic logic get_busy(input bit s);
    return s ? busy1 : busy0;
  endfunction

  function automatic logic [255:0] get_q(input bit s);
    return s ? q1 : q0;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) & 32'h1FF);
  endfunction

  task automatic drv(input bit s, input bit e, input bit w, input logic [31:0] a, input logic [255:0] d);
    if (s) begin
      en1 = e; wr1 = w; a1 = a; d1 = d;
    end else begin
      en0 = e; wr0 = w; a0 = a; d0 = d;
    end
  endtask

  task automatic xact(input bit s, input bit w, input logic [31:0] a, input logic [255:0] d,
                      input bit churn, input string tag);
    int n, lat, idx, c0;
    bit seen;
    logic [255:0] prev_q, exp;
    lat    = s ? 1 : 10;
    idx    = line_of(a);
    prev_q = get_q(s);
    if (!w) sb.push_back(s ? m1[idx] : m0[idx]);
    c0 = s ? ackc1 : ackc0;
    @(negedge clk);
    drv(s, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    drv(s, 1'b0, w, a, d);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (get_ack(s)) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_busy"}, 256'(get_busy(s)), 256'd1);
        if (churn) drv(s, 1'b0, 1'($urandom_range(0, 1)), $urandom, {8{$urandom}});
        @(posedge clk);
        n++;
      end
    end
    chk({tag, "_lat"}, seen ? 256'(n) : 256'd999, 256'(lat));
    if (seen) begin
      if (!w) begin
        exp = sb.pop_front();
        chk({tag, "_rd"}, get_q(s), exp);
      end else begin
        chk({tag, "_qhold"}, get_q(s), prev_q);
        if (s) m1[idx] = d;
        else   m0[idx] = d;
      end
    end else if (!w) begin
      void'(sb.pop_front());
    end
    drv(s, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ackdrop"}, 256'(get_ack(s)), 256'd0);
    chk({tag, "_idle"}, 256'(get_busy(s)), 256'd0);
    chk({tag, "_nack"}, 256'((s ? ackc1 : ackc0) - c0), 256'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q0", q0, '0);
    chk("rst_ack0", 256'(ack0), 256'd0);
    chk("rst_busy0", 256'(busy0), 256'd0);
    chk("rst_q1", q1, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xact(1'b0, 1'b1, 32'h0000_0000, PRE, 1'b0, "pre_w");
    xact(1'b0, 1'b1, 32'h0000_0020, L1D, 1'b0, "l1_w");
    xact(1'b0, 1'b0, 32'h0000_0000, '0, 1'b0, "rd0");

    xact(1'b0, 1'b1, 32'h0000_0040, ECFA, 1'b0, "ecfa_w");
    xact(1'b0, 1'b0, 32'h0000_0040, '0, 1'b0, "ecfa_r");
    xact(1'b0, 1'b0, 32'h0000_0020, '0, 1'b0, "l1_r");

    xact(1'b0, 1'b1, 32'h0000_0060, CHD, 1'b1, "churn_w");
    xact(1'b0, 1'b0, 32'h0000_0060, '0, 1'b1, "churn_r");
    repeat (5) @(negedge clk);
    chk("idle_hold", q0, CHD);

    // Held enable: ACK cycle plus one IDLE cycle separate the two acceptances.
    sb.push_back(m0[0]);
    sb.push_back(m0[0]);
    at_b[0] = -1;
    at_b[1] = -1;
    @(negedge clk);
    drv(1'b0, 1'b1, 1'b0, 32'h0, '0);
    @(posedge clk);
    n_b = 0;
    k_b = 0;
    while (k_b < 2 && n_b < 100) begin
      @(negedge clk);
      if (ack0) begin
        at_b[k_b] = n_b;
        chk("b2b_rd", q0, sb.pop_front());
        k_b++;
        if (k_b == 2) drv(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (k_b < 2) begin
        @(posedge clk);
        n_b++;
      end
    end
    drv(1'b0, 1'b0, 1'b0, '0, '0);
    sb.delete();
    chk("b2b_first", 256'(at_b[0]), 256'd10);
    chk("b2b_gap", 256'(at_b[1] - at_b[0]), 256'd12);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle", 256'(busy0), 256'd0);

    xact(1'b0, 1'b1, 32'h0000_0200, OLD, 1'b0, "old_w");
    c_r = ackc0;
    @(negedge clk);
    drv(1'b0, 1'b1, 1'b1, 32'h0000_0200, NEWD);
    @(posedge clk);
    #1;
    drv(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 256'(busy0), 256'd0);
    chk("midrst_ack", 256'(ack0), 256'd0);
    chk("midrst_q", q0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_noack", 256'(ackc0 - c_r), 256'd0);
    chk("midrst_idle", 256'(busy0), 256'd0);
    xact(1'b0, 1'b0, 32'h0000_0200, '0, 1'b0, "midrst_r");

    xact(1'b0, 1'b1, 32'h0000_4200, ALD, 1'b0, "alias_w");
    xact(1'b0, 1'b0, 32'h0000_0200, '0, 1'b0, "alias_r");

    xact(1'b1, 1'b1, 32'h0000_0060, F1D, 1'b0, "lat1_w");
    xact(1'b1, 1'b0, 32'h0000_0060, '0, 1'b0, "lat1_r");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
